// File: rtl/nios_project_keys.sv
// Avalon-MM key/switch input port: synchronised inputs, falling-edge capture, masked level IRQ.
// Define NIOS_PROJECT_KEYS_DEBOUNCE_EN to add a per-bit debounce filter of DEBOUNCE_CYCLES clocks.

`ifdef NIOS_PROJECT_KEYS_DEBOUNCE_EN
module nios_project_keys_lane #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic filt
);
    localparam logic [15:0] LIMIT = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] cnt;

    // Any return to agreement restarts the count, so glitches shorter than the limit vanish.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            filt <= 1'b1;
        end else if (raw == filt) begin
            cnt <= '0;
        end else if (cnt == LIMIT) begin
            filt <= raw;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end
endmodule
`endif

module nios_project_keys #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [7:0]  in_port,
    output logic [31:0] readdata,
    output logic        irq
);
    localparam int NUM_LANES = 8;

    logic [NUM_LANES-1:0] sync1, sync2, filt, prev, irqmask, edgecapture;
    logic [NUM_LANES-1:0] fall, clr;
    logic                 wr_en;
    logic                 unused_wdata;

    assign unused_wdata = ^writedata[31:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef NIOS_PROJECT_KEYS_DEBOUNCE_EN
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        nios_project_keys_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (sync2[i]),
            .filt    (filt[i])
        );
    end
`else
    assign filt = sync2;
`endif

    assign wr_en = chipselect & ~write_n;
    assign fall  = prev & ~filt;
    assign clr   = (wr_en && address == 2'd3) ? writedata[7:0] : '0;

    // OR-ing the new edges after the clear lets a same-cycle edge survive its own clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev        <= '1;
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            prev        <= filt;
            edgecapture <= (edgecapture & ~clr) | fall;
            if (wr_en && address == 2'd2)
                irqmask <= writedata[7:0];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[7:0] = filt;
            2'd2:    readdata[7:0] = irqmask;
            2'd3:    readdata[7:0] = edgecapture;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edgecapture & irqmask);
endmodule
